glitch_delay: RTL and testbench

GLITCH_DELAY -- requirements
Module: glitch_delay

---
 rtl/glitch_delay.sv | 89 ++++++++
 tb/tb_glitch_delay.sv | 133 +++++++++++++
 2 files changed

// File: rtl/glitch_delay.sv
// glitch_delay: armed one-shot that emits a glitch pulse a programmed number of
// cycles after a rising trigger edge, with programmable pulse width and abort.
module glitch_delay #(
   parameter int DELAY_W       = 32,
   parameter int WIDTH_W       = 16,
   parameter int DEFAULT_WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DELAY_W-1:0] delay,
   input  logic               set_delay,
   input  logic [WIDTH_W-1:0] pulse_width,
   input  logic               set_width,
   input  logic               arm,
   input  logic               abort,
   input  logic               trigger,
   output logic               glitch_out,
   output logic               armed,
   output logic               busy,
   output logic               done
);
   typedef enum logic [1:0] {IDLE, ARMED, COUNT, PULSE} state_t;
   state_t             state_q, state_d;
   logic [DELAY_W-1:0] delay_q, delay_d, cnt_q, cnt_d;
   logic [WIDTH_W-1:0] width_q, width_d, pcnt_q, pcnt_d;
   logic               trig_q, glitch_q, glitch_d, done_q, done_d, ev;
   assign ev = trigger & ~trig_q;
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pcnt_d   = pcnt_q;
      glitch_d = glitch_q;
      done_d   = 1'b0;
      delay_d  = set_delay ? delay : delay_q;
      width_d  = set_width ? pulse_width : width_q;
      if (abort) begin
         state_d  = IDLE;
         glitch_d = 1'b0;
      end else begin
         case (state_q)
            IDLE:  if (arm) state_d = ARMED;
            ARMED: if (!arm) state_d = IDLE;
                   else if (ev) begin
                      state_d = COUNT;
                      cnt_d   = delay_q;
                   end
            COUNT: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                   else begin
                      state_d  = PULSE;
                      glitch_d = 1'b1;
                      // zero width behaves as a single-cycle pulse
                      pcnt_d   = (width_q == '0) ? '0 : width_q - 1'b1;
                   end
            PULSE: if (pcnt_q != '0) pcnt_d = pcnt_q - 1'b1;
                   else begin
                      state_d  = IDLE;
                      glitch_d = 1'b0;
                      done_d   = 1'b1;
                   end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         delay_q  <= '0;
         width_q  <= WIDTH_W'(DEFAULT_WIDTH);
         cnt_q    <= '0;
         pcnt_q   <= '0;
         trig_q   <= 1'b0;
         glitch_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         delay_q  <= delay_d;
         width_q  <= width_d;
         cnt_q    <= cnt_d;
         pcnt_q   <= pcnt_d;
         trig_q   <= trigger;
         glitch_q <= glitch_d;
         done_q   <= done_d;
      end
   end
   assign glitch_out = glitch_q;
   assign done       = done_q;
   assign armed      = (state_q == ARMED);
   assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_glitch_delay.sv
// tb_glitch_delay: random and directed shots against a timestamp-based model,
// with expected outputs queued per edge and compared by an independent monitor.
module tb_glitch_delay;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] delay = '0;
   logic [15:0] pulse_width = '0;
   logic        set_delay = 1'b0, set_width = 1'b0, arm = 1'b0, abort = 1'b0, trigger = 1'b0;
   logic        glitch_out, armed, busy, done;
   int          checks = 0, errors = 0, glitch_seen = 0, done_seen = 0;
   logic [3:0]  exp_q[$];

   glitch_delay dut (
      .clk(clk), .rst(rst), .delay(delay), .set_delay(set_delay),
      .pulse_width(pulse_width), .set_width(set_width), .arm(arm),
      .abort(abort), .trigger(trigger), .glitch_out(glitch_out),
      .armed(armed), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Reference model: a shot is described by its event cycle t0, delay d and
   // width w; the pulse occupies cycles t0+d+1 .. t0+d+w, done at t0+d+w+1.
   int     mode;
   longint cyc, t0, d, w, dreg, wreg;
   bit     ptrig, wset;
   always @(posedge clk or posedge rst) begin
      logic done_e;
      if (rst) begin
         mode = 0; dreg = 0; wreg = 4; ptrig = 0; wset = 0;
         exp_q.delete();
         exp_q.push_back(4'b0000);
      end else begin
         cyc++;
         done_e = 0;
         if (abort) mode = 0;
         else if (mode == 0) begin
            if (arm) mode = 1;
         end else if (mode == 1) begin
            if (!arm) mode = 0;
            else if (trigger && !ptrig) begin
               mode = 2; t0 = cyc; d = dreg; wset = 0;
            end
         end else if (cyc == t0 + d + 1) begin
            w = (wreg == 0) ? 1 : wreg; wset = 1;
         end else if (wset && cyc == t0 + d + w + 1) begin
            mode = 0; done_e = 1;
         end
         ptrig = trigger;
         if (set_delay) dreg = delay;
         if (set_width) wreg = pulse_width;
         exp_q.push_back({mode == 2 && wset, mode == 1, mode != 0, done_e});
      end
   end

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [3:0] e, a;
         e = exp_q.pop_front();
         a = {glitch_out, armed, busy, done};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs t=%0t {glitch,armed,busy,done} got=%b exp=%b", $time, a, e);
         end
         glitch_seen += int'(glitch_out);
         done_seen += int'(done);
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input int dv, input int wv);
      delay = 32'(dv); pulse_width = 16'(wv); set_delay = 1; set_width = 1;
      step();
      set_delay = 0; set_width = 0;
   endtask

   task automatic shot(input int wait_n);
      arm = 1; step(2);
      trigger = 1; step();
      trigger = 0; step(wait_n);
   endtask

   initial begin
      step(3);
      rst = 0;
      step(2);
      load(5, 3);   shot(12);
      load(0, 0);   shot(6);
      arm = 0; step(2);
      trigger = 1; arm = 1; step(4);
      trigger = 0; step(); trigger = 1; step(10); trigger = 0;
      load(10, 2);  arm = 1; step(); trigger = 1; step(); trigger = 0;
      step(3); abort = 1; step(); abort = 0; arm = 0; step(3);
      arm = 1; step(); trigger = 1; step(); trigger = 0; step(2);
      delay = 2; set_delay = 1; step(); set_delay = 0; step(14);
      arm = 1; step(); arm = 0; step(); trigger = 1; step(); trigger = 0; step(15);
      load(2, 9);   arm = 1; step(); trigger = 1; step(); trigger = 0; step(4);
      #2 rst = 1;
      #1;
      checks++;
      if (glitch_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got glitch=%b busy=%b done=%b exp 000", glitch_out, busy, done);
      end
      step(2); rst = 0; step();
      shot(10);
      repeat (3000) begin
         arm = ($urandom % 16) != 0;
         abort = ($urandom % 60) == 0;
         if ($urandom % 3 == 0) trigger = ~trigger;
         set_delay = ($urandom % 20) == 0; delay = $urandom % 8;
         set_width = ($urandom % 20) == 0; pulse_width = 16'($urandom % 6);
         step();
      end
      arm = 0; abort = 0; set_delay = 0; set_width = 0; trigger = 0;
      step(3);
      @(negedge clk); #1;
      checks++;
      if (glitch_seen == 0 || done_seen == 0) begin
         errors++;
         $display("FAIL activity got glitch_cycles=%0d done_pulses=%0d exp nonzero", glitch_seen, done_seen);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
